// File: rtl/sync_pkg.sv
// ============================================================================
// Module : sync_pkg
// Brief  : Shared FSM encodings and default channel width for the sync_tx path
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sync_pkg;

    localparam int SYNC_N = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        HOLD   = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin picker, scans upward from ptr with wrap
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            valid,
    output logic [IW-1:0]   w
);

    logic [IW:0] w_pos;

    // Walk offsets from the far end down so the closest hit to ptr wins.
    always_comb begin
        valid = 1'b0;
        w     = '0;
        w_pos = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_pos = {1'b0, ptr} + (IW + 1)'(k);
            if (w_pos >= (IW + 1)'(NREQ)) begin
                w_pos = w_pos - (IW + 1)'(NREQ);
            end
            if (req[w_pos[IW-1:0]]) begin
                valid = 1'b1;
                w     = w_pos[IW-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sync_tx_sched.sv
// ============================================================================
// Module : sync_tx_sched
// Brief  : Round-robin scheduler feeding one toggle-synchronizer channel
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_tx_sched
    import sync_pkg::*;
#(
    parameter int N           = SYNC_N,
    parameter int NREQ        = 4,
    parameter int HOLD_CYCLES = 8
) (
    input  logic                     clkA,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*N-1:0]        req_data,
    output logic [NREQ-1:0]          gnt,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic [N-1:0]             ch_data,
    output logic                     ch_pulse,
    output logic                     busy
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(HOLD_CYCLES + 1);

    state_t         r_state;
    logic [IW-1:0]  r_ptr;
    logic [CW-1:0]  r_cnt;

    logic           w_valid;
    logic [IW-1:0]  w_win;
    logic [IW-1:0]  w_next_ptr;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req   (req),
        .ptr   (r_ptr),
        .valid (w_valid),
        .w     (w_win)
    );

    assign w_next_ptr = (w_win == IW'(NREQ - 1)) ? '0 : w_win + IW'(1);

    always_ff @(posedge clkA) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_cnt    <= '0;
            ch_data  <= '0;
            ch_pulse <= 1'b0;
            gnt      <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (ena && w_valid) begin
                        r_state  <= LAUNCH;
                        ch_data  <= req_data[w_win*N +: N];
                        ch_pulse <= 1'b1;
                        gnt      <= NREQ'(1) << w_win;
                        grant_id <= w_win;
                        busy     <= 1'b1;
                        r_ptr    <= w_next_ptr;
                    end
                end
                LAUNCH: begin
                    r_state  <= HOLD;
                    ch_pulse <= 1'b0;
                    gnt      <= '0;
                    r_cnt    <= CW'(HOLD_CYCLES - 1);
                end
                HOLD: begin
                    // ch_data is deliberately untouched here so the far side sees a stable word.
                    if (r_cnt == '0) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    ch_pulse <= 1'b0;
                    gnt      <= '0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sync_tx_sched.sv
// ============================================================================
// Module : tb_sync_tx_sched
// Brief  : Directed scoreboard bench for sync_tx_sched (N=8, NREQ=4, HOLD=8)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sync_tx_sched;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    logic        clkA = 1'b0;
    logic        rst_n;
    logic        ena;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic [1:0]  grant_id;
    logic [7:0]  ch_data;
    logic        ch_pulse;
    logic        busy;

    int   tests_run = 0;
    int   tests_failed = 0;
    bit   mon_en = 1'b0;
    exp_t sb[$];
    logic [7:0] lane [4] = '{8'h1E, 8'h71, 8'hA5, 8'h3C};

    sync_tx_sched #(
        .N           (8),
        .NREQ        (4),
        .HOLD_CYCLES (8)
    ) dut (
        .clkA     (clkA),
        .rst_n    (rst_n),
        .ena      (ena),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .grant_id (grant_id),
        .ch_data  (ch_data),
        .ch_pulse (ch_pulse),
        .busy     (busy)
    );

    always #5 clkA = ~clkA;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clkA);
            #1;
        end
    endtask

    task automatic push(input int id);
        exp_t e;
        e.gnt  = 4'b0001 << id;
        e.id   = 2'(id);
        e.data = lane[id];
        sb.push_back(e);
    endtask

    task automatic wait_pulse(output int lat);
        lat = 0;
        do begin
            tick(1);
            lat++;
        end while (!ch_pulse && lat < 30);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            tick(1);
            n++;
        end
        chk("idle_reached", 32'(busy), 32'd0);
    endtask

    task automatic do_xfer(input logic [3:0] rv, input int id, input string tag);
        int lat;
        req = rv;
        push(id);
        wait_pulse(lat);
        chk({tag, "_latency"}, lat, 32'd1);
        chk({tag, "_grant_id"}, 32'(grant_id), 32'(id));
        req = 4'b0000;
        wait_idle();
    endtask

    // Scoreboard side: every launch must match the oldest outstanding expectation.
    always @(negedge clkA) begin
        if (mon_en) begin
            chk("pulse_eq_or_gnt", 32'(ch_pulse), 32'(|gnt));
            chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            if (ch_pulse) begin
                chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_gnt", 32'(gnt), 32'(e.gnt));
                    chk("sb_grant_id", 32'(grant_id), 32'(e.id));
                    chk("sb_ch_data", 32'(ch_data), 32'(e.data));
                end
            end
        end
    end

    initial begin
        int lat;
        int n;
        bit bad;

        rst_n    = 1'b0;
        ena      = 1'b1;
        req      = 4'b1111;
        req_data = {lane[3], lane[2], lane[1], lane[0]};

        // Reset with all requests high.
        tick(2);
        mon_en = 1'b1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_ch_data", 32'(ch_data), 32'd0);
        chk("rst_ch_pulse", 32'(ch_pulse), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        req   = 4'b0000;
        rst_n = 1'b1;
        tick(1);
        chk("idle_no_pulse", 32'(ch_pulse), 32'd0);

        // Single request on lane 2.
        req = 4'b0100;
        push(2);
        wait_pulse(lat);
        chk("single_latency", lat, 32'd1);
        chk("single_gnt", 32'(gnt), 32'h4);
        req = 4'b0000;
        n = 0;
        bad = 1'b0;
        while (busy && n < 40) begin
            if (ch_data !== 8'hA5) bad = 1'b1;
            n++;
            tick(1);
        end
        chk("single_busy_cycles", n, 32'd9);
        chk("single_data_stable", 32'(bad), 32'd0);
        chk("single_data_kept", 32'(ch_data), 32'hA5);

        // Fairness from ptr=0 with all requests held.
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        req = 4'b1111;
        push(0); push(1); push(2); push(3); push(0);
        for (int k = 0; k < 5; k++) begin
            wait_pulse(lat);
            chk(k == 0 ? "fair_first_latency" : "fair_spacing", lat, k == 0 ? 32'd1 : 32'd10);
        end
        req = 4'b0000;
        wait_idle();

        // Wrap: ptr=1 -> grant 3, then 1001 -> 0, then 1001 -> 3.
        do_xfer(4'b1000, 3, "wrap_pre");
        do_xfer(4'b1001, 0, "wrap_a");
        do_xfer(4'b1001, 3, "wrap_b");

        // ena gating; in-flight transfer completes while ena is low.
        ena = 1'b0;
        req = 4'b0001;
        push(0);
        for (int k = 0; k < 5; k++) begin
            tick(1);
            chk("ena_blocked_pulse", 32'(ch_pulse), 32'd0);
        end
        ena = 1'b1;
        tick(1);
        chk("ena_release_pulse", 32'(ch_pulse), 32'd1);
        ena = 1'b0;
        req = 4'b0000;
        n = 0;
        while (busy && n < 40) begin
            n++;
            tick(1);
        end
        chk("ena_inflight_busy", n, 32'd9);
        chk("ena_data_kept", 32'(ch_data), 32'(lane[0]));
        ena = 1'b1;

        // Reset in HOLD at counter=4 abandons the transfer and clears ptr.
        req = 4'b0010;
        push(1);
        wait_pulse(lat);
        chk("mid_latency", lat, 32'd1);
        req = 4'b0000;
        tick(4);
        chk("mid_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick(1);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_ch_data", 32'(ch_data), 32'd0);
        chk("mid_gnt", 32'(gnt), 32'd0);
        rst_n = 1'b1;
        req = 4'b0011;
        push(0);
        wait_pulse(lat);
        chk("post_rst_latency", lat, 32'd1);
        chk("post_rst_grant_id", 32'(grant_id), 32'd0);
        req = 4'b0000;
        wait_idle();
        tick(3);
        chk("sb_drained", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sync_tx_sched.md
SYNC_TX_SCHED -- requirements
Module: sync_tx_sched

Interface
REQ-001 The block SHALL have parameter N, default 8: payload width per requester, equal to the toggle-synchronizer channel width.
REQ-002 The block SHALL have parameter NREQ, default 4: number of requesters, at least 2.
REQ-003 The block SHALL have parameter HOLD_CYCLES, default 8: clkA cycles that ch_data is held after the launch cycle, at least 1.
REQ-004 The block SHALL have port clkA, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port ena, input, 1 bit: high permits new grants.
REQ-007 The block SHALL have port req, input, NREQ bits: per-requester transfer request, level, held until granted.
REQ-008 The block SHALL have port req_data, input, NREQ*N bits: payload of requester i at bits [i*N +: N], stable while req[i] is high.
REQ-009 The block SHALL have port gnt, output, NREQ bits: one-hot, one-cycle accept strobe.
REQ-010 The block SHALL have port grant_id, output, $clog2(NREQ) bits: index of the last granted requester.
REQ-011 The block SHALL have port ch_data, output, N bits: payload to the synchronizer channel data input.
REQ-012 The block SHALL have port ch_pulse, output, 1 bit: one-cycle launch strobe to the synchronizer channel pulse input.
REQ-013 The block SHALL have port busy, output, 1 bit: high while a transfer is in LAUNCH or HOLD.

Function
REQ-014 The FSM SHALL have three states, IDLE, LAUNCH and HOLD, and all outputs SHALL be registered.
REQ-015 In IDLE, when ena=1 and |req=1, the block SHALL select winner w by round-robin, scanning from pointer ptr upward with wrap from NREQ-1 to 0.
REQ-016 At the following edge the block SHALL enter LAUNCH and set ch_data=req_data[w], ch_pulse=1, gnt[w]=1, grant_id=w, busy=1 and ptr=(w+1) mod NREQ.
REQ-017 LAUNCH SHALL last exactly one cycle, then HOLD is entered with ch_pulse=0, gnt=0 and hold counter=HOLD_CYCLES-1.
REQ-018 In HOLD the counter SHALL decrement each cycle; at counter=0 the next state is IDLE with busy=0.
REQ-019 ch_data SHALL remain constant from LAUNCH until the next LAUNCH, and SHALL never change during HOLD.
REQ-020 busy SHALL be high for exactly 1+HOLD_CYCLES cycles per transfer.
REQ-021 The minimum spacing between ch_pulse assertions SHALL be HOLD_CYCLES+2 cycles, achieved under continuous requests.
REQ-022 req SHALL be sampled only in IDLE; requests raised or dropped during LAUNCH/HOLD SHALL have no effect, and a request dropped before grant SHALL not be served.
REQ-023 ena=0 SHALL block new grants only; an in-flight LAUNCH/HOLD sequence SHALL complete unchanged.
REQ-024 The hold counter SHALL be $clog2(HOLD_CYCLES+1) bits wide and SHALL never wrap below 0.
REQ-025 gnt SHALL be all-zero or one-hot at all times, and ch_pulse SHALL equal |gnt.

Reset
REQ-026 When rst_n=0 at a clock edge, the block SHALL set state=IDLE, ptr=0, counter=0, ch_data=0, ch_pulse=0, gnt=0, grant_id=0 and busy=0.
REQ-027 Reset during LAUNCH or HOLD SHALL abandon the transfer at that edge; no pulse is reissued after reset.
REQ-028 The first cycle after reset release SHALL be IDLE and eligible to grant.

Structure
REQ-029 The FSM state encodings (IDLE=2'd0, LAUNCH=2'd1, HOLD=2'd2) SHALL reside in shared package sync_pkg, with the default N shared with the synchronizer.
REQ-030 Round-robin selection SHALL be a combinational sub-module rr_arbiter (inputs req and ptr; outputs valid and index w), instantiated once.

Verification
REQ-031 Reset: rst_n=0 for 2 cycles with req=4'b1111 -> all outputs 0 and no ch_pulse.
REQ-032 Single request: req=4'b0100 with payload 0xA5 -> next cycle ch_pulse=1 for 1 cycle, gnt=4'b0100, grant_id=2, ch_data=0xA5; busy high for 9 cycles.
REQ-033 Fairness: req=4'b1111 held with HOLD_CYCLES=8 -> grant order 0,1,2,3,0 with ch_pulse exactly 10 cycles apart.
REQ-034 Wrap: after grant 3, req=4'b1001 -> grant 0; then req=4'b1001 again -> grant 3.
REQ-035 ena gating: req=4'b0001 with ena=0 for 5 cycles -> no pulse; ena raised -> ch_pulse on the next edge.
REQ-036 Mid-reset: rst_n=0 for 1 cycle at HOLD counter=4 -> next cycle busy=0, ch_data=0, ptr=0, and req=4'b0011 -> grant 0.
